// File: rtl/lmc1992_ctrl_if.sv
// Microwire link from the DMA-sound register block to the LMC1992 emulation.
// The register block drives the master side and the controller listens on the slave side.
interface lmc1992_ctrl_if;
  logic mw_stb;
  logic mw_clk;
  logic mw_data;
  logic mw_done;

  modport master (output mw_stb, mw_clk, mw_data, mw_done);
  modport slave  (input  mw_stb, mw_clk, mw_data, mw_done);
endinterface

// File: rtl/lmc1992_ctrl.sv
// STE LMC1992 emulation: microwire deserialiser, command decoder, and per-channel
// attenuation ramp with a registered linear-gain lookup.
module lmc1992_ctrl #(
  parameter bit RAMP  = 1'b1,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  lmc1992_ctrl_if.slave        mw,
  input  logic                 sample_en,
  output logic [1:0]           mix,
  output logic [3:0]           bass,
  output logic [3:0]           treble,
  output logic [5:0]           master,
  output logic [4:0]           vol_r,
  output logic [4:0]           vol_l,
  output logic [5:0]           atten_l,
  output logic [5:0]           atten_r,
  output logic [7:0]           gain_l,
  output logic [7:0]           gain_r,
  output logic                 cfg_stb,
  output logic                 frame_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(11);

  logic [1:0]       state;
  logic [10:0]      sh;
  logic [CNT_W-1:0] cnt;
  logic             done_q;

  logic       bit_stb;
  logic       done_rise;
  logic [1:0] f_addr;
  logic [2:0] f_cmd;
  logic [5:0] f_data;
  logic [5:0] tgt_l;
  logic [5:0] tgt_r;

  assign bit_stb   = mw.mw_stb & mw.mw_clk;
  assign done_rise = mw.mw_done & ~done_q;
  assign f_addr    = sh[10:9];
  assign f_cmd     = sh[8:6];
  assign f_data    = sh[5:0];

  // Both operands are bounded (master<=40, vol<=20), so this never underflows.
  assign tgt_l = 6'd60 - master - {1'b0, vol_l};
  assign tgt_r = 6'd60 - master - {1'b0, vol_r};

  function automatic logic [3:0] clamp12(input logic [3:0] v);
    return (v > 4'd12) ? 4'd12 : v;
  endfunction

  function automatic logic [4:0] clamp20(input logic [4:0] v);
    return (v > 5'd20) ? 5'd20 : v;
  endfunction

  function automatic logic [5:0] clamp40(input logic [5:0] v);
    return (v > 6'd40) ? 6'd40 : v;
  endfunction

  function automatic logic [5:0] step_toward(input logic [5:0] cur, input logic [5:0] tgt);
    if (cur < tgt)      return cur + 6'd1;
    else if (cur > tgt) return cur - 6'd1;
    else                return cur;
  endfunction

  // round(255 * 10^(-a/10)); everything from 28 upward rounds to silence.
  function automatic logic [7:0] gain_rom(input logic [5:0] a);
    case (a)
      6'd0:  return 8'd255;  6'd1:  return 8'd203;  6'd2:  return 8'd161;
      6'd3:  return 8'd128;  6'd4:  return 8'd102;  6'd5:  return 8'd81;
      6'd6:  return 8'd64;   6'd7:  return 8'd51;   6'd8:  return 8'd40;
      6'd9:  return 8'd32;   6'd10: return 8'd26;   6'd11: return 8'd20;
      6'd12: return 8'd16;   6'd13: return 8'd13;   6'd14: return 8'd10;
      6'd15: return 8'd8;    6'd16: return 8'd6;    6'd17: return 8'd5;
      6'd18: return 8'd4;    6'd19: return 8'd3;    6'd20: return 8'd3;
      6'd21: return 8'd2;    6'd22: return 8'd2;    6'd23: return 8'd1;
      6'd24: return 8'd1;    6'd25: return 8'd1;    6'd26: return 8'd1;
      6'd27: return 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sh        <= '0;
      cnt       <= '0;
      // NOTE: edge detector resets high so a level already high after reset is not an edge.
      done_q    <= 1'b1;
      cfg_stb   <= 1'b0;
      frame_err <= 1'b0;
      mix       <= 2'b01;
      bass      <= 4'd6;
      treble    <= 4'd6;
      master    <= 6'd40;
      vol_r     <= 5'd20;
      vol_l     <= 5'd20;
    end else begin
      done_q    <= mw.mw_done;
      cfg_stb   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bit_stb) begin
            sh    <= {sh[9:0], mw.mw_data};
            cnt   <= CNT_W'(1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_stb) begin
            sh <= {sh[9:0], mw.mw_data};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
          if (done_rise) state <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          if (cnt < FRAME_LEN) begin
            frame_err <= 1'b1;
          end else if (f_addr == 2'b10) begin
            case (f_cmd)
              3'b000: begin mix    <= f_data[1:0];          cfg_stb <= 1'b1; end
              3'b001: begin bass   <= clamp12(f_data[3:0]); cfg_stb <= 1'b1; end
              3'b010: begin treble <= clamp12(f_data[3:0]); cfg_stb <= 1'b1; end
              3'b011: begin master <= clamp40(f_data);      cfg_stb <= 1'b1; end
              3'b100: begin vol_r  <= clamp20(f_data[4:0]); cfg_stb <= 1'b1; end
              3'b101: begin vol_l  <= clamp20(f_data[4:0]); cfg_stb <= 1'b1; end
              default: frame_err <= 1'b1;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      atten_l <= '0;
      atten_r <= '0;
      gain_l  <= 8'd255;
      gain_r  <= 8'd255;
    end else begin
      gain_l <= gain_rom(atten_l);
      gain_r <= gain_rom(atten_r);
      if (!RAMP) begin
        atten_l <= tgt_l;
        atten_r <= tgt_r;
      end else if (sample_en) begin
        atten_l <= step_toward(atten_l, tgt_l);
        atten_r <= step_toward(atten_r, tgt_r);
      end
    end
  end

endmodule
